mul_err_accum: RTL
==================

MUL_ERR_ACCUM -- requirements
Module: mul_err_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, multiplier operand width; product width PW = 2*WIDTH+1.
REQ-002 SHALL have parameter CNT_W, default 16, width of sample counters.
REQ-003 SHALL have parameter ACC_W, default 32, width of the error-sum accumulator.
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  begin a measurement run (pulse).
REQ-007 SHALL have port num_samples  input  CNT_W  samples per run, sampled on accepted start.
REQ-008 SHALL have port in_valid  input  1  approx/exact pair valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-010 SHALL have port approx  input  PW  unsigned approximate multiplier product.
REQ-011 SHALL have port exact  input  PW  unsigned exact product.
REQ-012 SHALL have port busy  output  1  run in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have ports sum_ed (ACC_W), max_ed (PW), err_count (CNT_W), sat (1), all outputs: error-distance sum, maximum error distance, count of pairs with approx != exact, accumulator-saturated flag.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy = 1 in RUN and DRAIN only.
REQ-016 IDLE: start=1 with num_samples!=0 SHALL clear sum_ed, max_ed, err_count, sat, latch num_samples, and enter RUN next cycle.
REQ-017 IDLE: start=1 with num_samples==0 SHALL clear results and enter DONE next cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a pair is accepted when in_valid && in_ready.
REQ-020 Stage 1 SHALL register ed = |approx - exact| (PW bits, unsigned) and a mismatch bit on the cycle after acceptance.
REQ-021 Stage 2 SHALL, one cycle later, add ed to sum_ed, update max_ed = max(max_ed, ed), increment err_count on mismatch.
REQ-022 sum_ed SHALL saturate at 2^ACC_W-1; sat SHALL set on first overflow and stay set until next accepted start.
REQ-023 Acceptance of the num_samples-th pair SHALL move RUN to DRAIN; DRAIN SHALL last exactly 2 cycles, then DONE.
REQ-024 DONE SHALL last 1 cycle with done=1, then IDLE; results SHALL hold until the next accepted start.
REQ-025 in_valid gaps SHALL only stall; results SHALL be independent of gap pattern.
REQ-026 Inputs while in_ready=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and zero all outputs and internal registers (in_ready=0, busy=0, done=0).
REQ-028 Reset mid-RUN or mid-DRAIN SHALL abandon the run; no done pulse follows.

Configuration
REQ-029 Macro MUL_ERR_SQ_EN defined SHALL add output sum_sq (2*ACC_W bits), accumulating ed*ed in stage 2, saturating at all-ones, setting sat on overflow, cleared with other results.
REQ-030 Without MUL_ERR_SQ_EN the sum_sq port and squaring logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8 unless noted)
REQ-031 Reset release -> all outputs 0, in_ready=0, state IDLE.
REQ-032 start at cycle 0, num_samples=3, in_valid held high with pairs (100,100),(50,52),(300,290) -> accepted cycles 1-3, done=1 only at cycle 6, sum_ed=12, max_ed=10, err_count=2, sat=0 (sum_sq=104 with MUL_ERR_SQ_EN).
REQ-033 Same pairs with one idle in_valid cycle between each -> identical results, done 2 cycles later than REQ-032.
REQ-034 start with num_samples=0 at cycle 0 -> done=1 at cycle 1, all results 0, in_ready never 1.
REQ-035 ACC_W=8, num_samples=2, pairs (200,0),(200,0) -> sum_ed=255, sat=1, max_ed=200, err_count=2.
REQ-036 rst_n low after 1 of 3 samples accepted -> outputs 0 immediately, no done; fresh run of REQ-032 then passes.

Source files
------------

// File: rtl/mul_err_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_err_accum_if                                           |
// | Description : Sample-pair handshake bus into mul_err_accum.              |
// |               in_valid - approx/exact pair present (master -> slave)     |
// |               in_ready - slave takes the pair this cycle (slave->master) |
// |               approx   - approximate product, 2*WIDTH+1 bits unsigned    |
// |               exact    - exact product,       2*WIDTH+1 bits unsigned    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface mul_err_accum_if #(
   parameter int WIDTH = 8
);
   localparam int PW = 2*WIDTH + 1;

   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] approx;
   logic [PW-1:0] exact;

   modport master (output in_valid, output approx, output exact, input  in_ready);
   modport slave  (input  in_valid, input  approx, input  exact, output in_ready);
endinterface
`default_nettype wire

// File: rtl/mul_err_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_err_accum                                              |
// | Description : Error-metric accumulator for an approximate multiplier.    |
// |               A run is started by 'start' in IDLE; num_samples pairs are |
// |               taken over the bus, each through a 2-stage pipe            |
// |               (|approx-exact| register, then accumulate).                |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               start, num_samples     - run control, taken in IDLE only   |
// |               bus (slave)            - in_valid/in_ready/approx/exact    |
// |               busy, done             - RUN/DRAIN flag, 1-cycle end pulse |
// |               sum_ed, max_ed,        - error-distance sum (saturating),  |
// |               err_count, sat           max, mismatch count, sat flag     |
// |               sum_sq                 - sum of ed^2 (MUL_ERR_SQ_EN only)  |
// | Options     : `define MUL_ERR_SQ_EN adds the squared-error accumulator.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mul_err_accum #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   parameter int ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   mul_err_accum_if.slave       bus,
   output logic                 busy,
   output logic                 done,
   output logic [ACC_W-1:0]     sum_ed,
   output logic [2*WIDTH:0]     max_ed,
   output logic [CNT_W-1:0]     err_count,
`ifdef MUL_ERR_SQ_EN
   output logic [2*ACC_W-1:0]   sum_sq,
`endif
   output logic                 sat
);
   localparam int PW    = 2*WIDTH + 1;
   // one spare bit above the wider operand exposes the carry-out
   localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             drain_q, drain_d;
   logic             s1_vld_q, s1_vld_d;
   logic [PW-1:0]    s1_ed_q, s1_ed_d;
   logic             s1_mis_q, s1_mis_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [PW-1:0]    max_q, max_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   logic             start_acc;
   logic             accept;
   logic             in_ready;
   logic [PW-1:0]    ed_in;
   logic [SUM_W-1:0] sum_ext;
   logic             sum_ovf;
   logic             sq_ovf;

`ifdef MUL_ERR_SQ_EN
   localparam int SQ_W = ((2*ACC_W > 2*PW) ? 2*ACC_W : 2*PW) + 1;
   logic [2*ACC_W-1:0] sq_q, sq_d;
   logic [2*PW-1:0]    ed_sq;
   logic [SQ_W-1:0]    sq_ext;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (num_samples == '0) ? S_DONE : S_RUN;
         S_RUN:   if (accept && (rem_q == CNT_W'(1))) state_d = S_DRAIN;
         // two DRAIN cycles let the last pair clear both pipeline stages
         S_DRAIN: if (drain_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- state outputs ----------------
   always_comb begin
      in_ready  = (state_q == S_RUN);
      busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
      done      = (state_q == S_DONE);
      start_acc = (state_q == S_IDLE) && start;
      accept    = bus.in_valid && in_ready;
   end

   assign bus.in_ready = in_ready;

   // ---------------- datapath next values ----------------
   always_comb begin
      rem_d    = rem_q;
      if (start_acc)   rem_d = num_samples;
      else if (accept) rem_d = rem_q - CNT_W'(1);
      drain_d  = (state_q == S_DRAIN) ? ~drain_q : 1'b0;

      // stage 1: absolute error distance of the accepted pair
      ed_in    = (bus.approx >= bus.exact) ? (bus.approx - bus.exact)
                                           : (bus.exact - bus.approx);
      s1_vld_d = accept;
      s1_ed_d  = accept ? ed_in : s1_ed_q;
      s1_mis_d = accept ? (bus.approx != bus.exact) : s1_mis_q;

      // stage 2: saturating accumulate
      sum_ext  = SUM_W'(sum_q) + SUM_W'(s1_ed_q);
      sum_ovf  = |sum_ext[SUM_W-1:ACC_W];
`ifdef MUL_ERR_SQ_EN
      ed_sq    = (2*PW)'(s1_ed_q) * (2*PW)'(s1_ed_q);
      sq_ext   = SQ_W'(sq_q) + SQ_W'(ed_sq);
      sq_ovf   = |sq_ext[SQ_W-1:2*ACC_W];
      sq_d     = sq_q;
`else
      sq_ovf   = 1'b0;
`endif
      sum_d    = sum_q;
      max_d    = max_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      if (start_acc) begin
         sum_d = '0;
         max_d = '0;
         cnt_d = '0;
         sat_d = 1'b0;
`ifdef MUL_ERR_SQ_EN
         sq_d  = '0;
`endif
      end else if (s1_vld_q) begin
         sum_d = sum_ovf ? '1 : sum_ext[ACC_W-1:0];
         max_d = (s1_ed_q > max_q) ? s1_ed_q : max_q;
         cnt_d = cnt_q + CNT_W'(s1_mis_q);
         sat_d = sat_q | sum_ovf | sq_ovf;
`ifdef MUL_ERR_SQ_EN
         sq_d  = sq_ovf ? '1 : sq_ext[2*ACC_W-1:0];
`endif
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= '0;
         drain_q  <= 1'b0;
         s1_vld_q <= 1'b0;
         s1_ed_q  <= '0;
         s1_mis_q <= 1'b0;
         sum_q    <= '0;
         max_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
`ifdef MUL_ERR_SQ_EN
         sq_q     <= '0;
`endif
      end else begin
         rem_q    <= rem_d;
         drain_q  <= drain_d;
         s1_vld_q <= s1_vld_d;
         s1_ed_q  <= s1_ed_d;
         s1_mis_q <= s1_mis_d;
         sum_q    <= sum_d;
         max_q    <= max_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
`ifdef MUL_ERR_SQ_EN
         sq_q     <= sq_d;
`endif
      end
   end

   assign sum_ed    = sum_q;
   assign max_ed    = max_q;
   assign err_count = cnt_q;
   assign sat       = sat_q;
`ifdef MUL_ERR_SQ_EN
   assign sum_sq    = sq_q;
`endif

endmodule
`default_nettype wire
